// File: rtl/avmm_pkg.sv
// Shared types and default geometry for the Avalon-MM burst responder.
package avmm_pkg;

  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 128;
  localparam int unsigned BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/be_sp_ram.sv
// Single-port byte-enabled RAM with a registered read port (one-cycle latency).
module be_sp_ram #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Byte-lane writes; storage is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read port: capture the addressed word only when a read is issued.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[addr];
    end
  end

  // Output register, cleared by reset so readdata starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avmm_burst_responder.sv
// Avalon-MM burst slave backed by on-chip byte-enabled RAM; fixed one-cycle read latency.
module avmm_burst_responder
  import avmm_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned BURST_W = BURST_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     avs_address,
  input  logic [BURST_W-1:0]    avs_burstcount,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic                  avs_waitrequest,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  err
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 wait_q, wait_d;
  logic                 rdv_q, rdv_d;

  logic                 accept_c;
  logic [BURST_W-1:0]   n_eff_c;
  logic                 ram_rd_c, ram_we_c;
  logic [ADDR_W-1:0]    ram_addr_c;

  // A zero burstcount behaves as a single beat.
  assign n_eff_c  = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;
  // Commands are only taken in IDLE once waitrequest has dropped after reset.
  assign accept_c = (state_q == IDLE) && !wait_q && (avs_read || avs_write);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c && (n_eff_c > BURST_W'(1))) begin
          state_d = avs_write ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (cnt_q <= BURST_W'(1)) begin
          state_d = IDLE;
        end
      end
      WR_BURST: begin
        if (avs_write && (cnt_q <= BURST_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath: RAM port control, address/beat counters, error flag.
  always_comb begin
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdv_d      = 1'b0;
    ram_rd_c   = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr_c = addr_q;
    wait_d     = (state_d == RD_BURST);
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          ram_addr_c = avs_address;
          addr_d     = avs_address + 1'b1;
          cnt_d      = n_eff_c - 1'b1;
          if (avs_burstcount == '0) begin
            err_d = 1'b1;
          end
          if (avs_write) begin
            ram_we_c = 1'b1;
            if (avs_read) begin
              err_d = 1'b1;
            end
          end else begin
            ram_rd_c = 1'b1;
            rdv_d    = 1'b1;
          end
        end
      end
      RD_BURST: begin
        ram_rd_c = 1'b1;
        rdv_d    = 1'b1;
        addr_d   = addr_q + 1'b1;
        cnt_d    = cnt_q - 1'b1;
      end
      WR_BURST: begin
        if (avs_read) begin
          err_d = 1'b1;
        end
        if (avs_write) begin
          ram_we_c = 1'b1;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; waitrequest held high throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      wait_q <= 1'b1;
      rdv_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      wait_q <= wait_d;
      rdv_q  <= rdv_d;
    end
  end

  // Backing store; any beat in flight while reset is asserted is dropped.
  be_sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .rd_en (ram_rd_c && rst_n),
    .wr_en (ram_we_c && rst_n),
    .addr  (ram_addr_c),
    .wdata (avs_writedata),
    .be    (avs_byteenable),
    .rdata (avs_readdata)
  );

  assign avs_waitrequest   = wait_q;
  assign avs_readdatavalid = rdv_q;
  assign err               = err_q;

endmodule

// File: tb/tb_avmm_burst_responder.sv
// Directed bench for avmm_burst_responder: bursts, partial writes, wrap, stalls, errors, reset.
module tb_avmm_burst_responder;

  logic          clk;
  logic          rst_n;
  logic [11:0]   avs_address;
  logic [7:0]    avs_burstcount;
  logic          avs_read;
  logic          avs_write;
  logic [127:0]  avs_writedata;
  logic [15:0]   avs_byteenable;
  logic          avs_waitrequest;
  logic [127:0]  avs_readdata;
  logic          avs_readdatavalid;
  logic          err;

  int            n_cmp;
  int            n_fail;
  logic [127:0]  mdl [4096];
  logic [127:0]  last_rd;

  avmm_burst_responder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .avs_address       (avs_address),
    .avs_burstcount    (avs_burstcount),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pat(input logic [7:0] s, input int k);
    return {{15{s}}, 8'(8'hA0 + k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One write beat; mdl_addr is where the bench expects it to land.
  task automatic wr_beat(input logic [11:0] mdl_addr, input logic [11:0] a, input logic [7:0] bc,
                         input logic [127:0] d, input logic [15:0] be, input logic rd);
    avs_address    = a;
    avs_burstcount = bc;
    avs_write      = 1'b1;
    avs_read       = rd;
    avs_writedata  = d;
    avs_byteenable = be;
    chk("wr_wait", 128'(avs_waitrequest), 128'(0));
    tick();
    for (int b = 0; b < 16; b++) begin
      if (be[b]) mdl[mdl_addr][8*b +: 8] = d[8*b +: 8];
    end
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic wr_burst(input logic [11:0] a, input int n, input logic [7:0] s,
                          input int stall, input logic rd_during);
    for (int k = 0; k < n; k++) begin
      if (k == 1) begin
        for (int j = 0; j < stall; j++) begin
          avs_write = 1'b0;
          chk("wr_stall_wait", 128'(avs_waitrequest), 128'(0));
          tick();
        end
      end
      wr_beat(a + 12'(k), a, 8'(n), pat(s, k), 16'hFFFF, rd_during && (k > 0));
    end
  endtask

  task automatic rd_burst(input logic [11:0] a, input int n, input logic junk_wr);
    avs_read       = 1'b1;
    avs_address    = a;
    avs_burstcount = 8'(n);
    chk("rd_cmd_wait", 128'(avs_waitrequest), 128'(0));
    tick();
    avs_read = 1'b0;
    for (int k = 0; k < n; k++) begin
      avs_write      = junk_wr && (k < n - 1);
      avs_writedata  = {4{32'hDEADBEEF}};
      avs_byteenable = 16'hFFFF;
      chk("rd_valid", 128'(avs_readdatavalid), 128'(1));
      chk("rd_data", avs_readdata, mdl[a + 12'(k)]);
      chk("rd_wait", 128'(avs_waitrequest), 128'(k < n - 1));
      last_rd = avs_readdata;
      tick();
    end
    avs_write = 1'b0;
    chk("rd_after_valid", 128'(avs_readdatavalid), 128'(0));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    tick();
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_wait", 128'(avs_waitrequest), 128'(1));
    chk("rst_valid", 128'(avs_readdatavalid), 128'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_rel_wait", 128'(avs_waitrequest), 128'(0));
  endtask

  initial begin
    n_cmp          = 0;
    n_fail         = 0;
    last_rd        = '0;
    rst_n          = 1'b0;
    avs_address    = '0;
    avs_burstcount = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;

    // Reset values.
    tick(); tick(); tick();
    chk("init_wait", 128'(avs_waitrequest), 128'(1));
    chk("init_valid", 128'(avs_readdatavalid), 128'(0));
    chk("init_rdata", avs_readdata, 128'(0));
    chk("init_err", 128'(err), 128'(0));
    rst_n = 1'b1;
    chk("init_wait_pre_edge", 128'(avs_waitrequest), 128'(1));
    tick();
    chk("init_wait_released", 128'(avs_waitrequest), 128'(0));

    // Basic write burst then read burst.
    wr_burst(12'h010, 4, 8'h11, 0, 1'b0);
    rd_burst(12'h010, 4, 1'b0);
    chk("basic_beat3", last_rd, {{15{8'h11}}, 8'hA3});
    chk("basic_err", 128'(err), 128'(0));

    // Writes presented during a read burst are ignored without error.
    rd_burst(12'h010, 4, 1'b1);
    chk("wr_in_rd_err", 128'(err), 128'(0));
    rd_burst(12'h010, 4, 1'b0);

    // Partial byte-enable write.
    wr_beat(12'h020, 12'h020, 8'd1, {128{1'b1}}, 16'hFFFF, 1'b0);
    wr_beat(12'h020, 12'h020, 8'd1, 128'(0), 16'h000F, 1'b0);
    rd_burst(12'h020, 1, 1'b0);
    chk("partial_hand", last_rd, {{96{1'b1}}, 32'h0});

    // Address wrap at the top of the RAM.
    wr_burst(12'hFFE, 4, 8'h22, 0, 1'b0);
    rd_burst(12'hFFE, 4, 1'b0);
    rd_burst(12'h000, 2, 1'b0);
    chk("wrap_word1", last_rd, {{15{8'h22}}, 8'hA3});

    // Back-to-back reads N=2 then N=3: five contiguous valid beats.
    avs_read = 1'b1; avs_address = 12'h010; avs_burstcount = 8'd2;
    tick();
    avs_address = 12'hFFE; avs_burstcount = 8'd3;
    chk("b2b_v0", 128'(avs_readdatavalid), 128'(1));
    chk("b2b_d0", avs_readdata, mdl[12'h010]);
    chk("b2b_w0", 128'(avs_waitrequest), 128'(1));
    tick();
    chk("b2b_v1", 128'(avs_readdatavalid), 128'(1));
    chk("b2b_d1", avs_readdata, mdl[12'h011]);
    chk("b2b_w1", 128'(avs_waitrequest), 128'(0));
    tick();
    avs_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("b2b_v2", 128'(avs_readdatavalid), 128'(1));
      chk("b2b_d2", avs_readdata, mdl[12'hFFE + 12'(k)]);
      chk("b2b_w2", 128'(avs_waitrequest), 128'(k < 2));
      tick();
    end
    chk("b2b_end", 128'(avs_readdatavalid), 128'(0));

    // Write burst with a two-cycle master stall after beat 0.
    wr_burst(12'h100, 4, 8'h33, 0, 1'b0);
    wr_burst(12'h100, 3, 8'h44, 2, 1'b0);
    rd_burst(12'h100, 4, 1'b0);
    chk("stall_untouched", last_rd, {{15{8'h33}}, 8'hA3});
    chk("stall_err", 128'(err), 128'(0));

    // burstcount=0 acts as a single beat and flags an error.
    wr_burst(12'h300, 2, 8'h54, 0, 1'b0);
    wr_beat(12'h300, 12'h300, 8'd0, pat(8'h55, 0), 16'hFFFF, 1'b0);
    chk("bc0_err", 128'(err), 128'(1));
    rd_burst(12'h300, 2, 1'b0);
    chk("bc0_next_word", last_rd, {{15{8'h54}}, 8'hA1});

    // Read and write together: write wins, read dropped, error raised.
    reset_pulse();
    avs_read = 1'b1;
    wr_beat(12'h200, 12'h200, 8'd1, pat(8'h77, 0), 16'hFFFF, 1'b1);
    chk("rw_err", 128'(err), 128'(1));
    chk("rw_no_valid", 128'(avs_readdatavalid), 128'(0));
    rd_burst(12'h200, 1, 1'b0);

    // Read asserted during a write burst: ignored, error raised.
    reset_pulse();
    wr_burst(12'h210, 2, 8'h66, 0, 1'b1);
    chk("rd_in_wr_err", 128'(err), 128'(1));
    rd_burst(12'h210, 2, 1'b0);

    // Reset in the middle of an 8-beat read burst.
    avs_read = 1'b1; avs_address = 12'h010; avs_burstcount = 8'd8;
    tick();
    avs_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("mid_v", 128'(avs_readdatavalid), 128'(1));
      chk("mid_d", avs_readdata, mdl[12'h010 + 12'(k)]);
      if (k == 2) rst_n = 1'b0;
      tick();
    end
    chk("mid_rst_valid", 128'(avs_readdatavalid), 128'(0));
    chk("mid_rst_wait", 128'(avs_waitrequest), 128'(1));
    chk("mid_rst_err", 128'(err), 128'(0));
    chk("mid_rst_rdata", avs_readdata, 128'(0));
    tick();
    chk("mid_hold_valid", 128'(avs_readdatavalid), 128'(0));
    rst_n = 1'b1;
    chk("mid_hold_wait", 128'(avs_waitrequest), 128'(1));
    tick();
    chk("mid_rel_wait", 128'(avs_waitrequest), 128'(0));
    chk("mid_rel_valid", 128'(avs_readdatavalid), 128'(0));
    rd_burst(12'h010, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/avmm_burst_responder.md
# avmm_burst_responder

Avalon-MM burst slave that terminates the 128-bit SDRAM-side protocol driven by the register-file load/store engine. It backs the bus with an on-chip byte-enabled RAM, accepts pipelined read and write bursts, and returns read beats with fixed one-cycle latency. It stands in for external SDRAM in simulation and serves as an on-chip weight/scratch buffer in small builds.

## Interface

Parameters:
- ADDR_W, 12, word-address width; depth = 2^ADDR_W words.
- DATA_W, 128, beat width; must be a multiple of 8.
- BURST_W, 8, burstcount width; max legal burst 2^(BURST_W-1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- avs_address  in  ADDR_W  word address of first beat.
- avs_burstcount  in  BURST_W  beats in burst.
- avs_read  in  1  read command.
- avs_write  in  1  write command / write beat.
- avs_writedata  in  DATA_W  write beat data.
- avs_byteenable  in  DATA_W/8  per-byte write enable.
- avs_waitrequest  out  1  high = command/beat not accepted.
- avs_readdata  out  DATA_W  read beat data.
- avs_readdatavalid  out  1  avs_readdata valid this cycle.
- err  out  1  sticky protocol-error flag.

## Operation

- States: IDLE, RD_BURST, WR_BURST.
- IDLE: waitrequest=0. Command accepted when read or write high.
- Read accept (cycle T, addr A, count N): RAM read A issued in T; next addresses A+1.. issued one per cycle; if N>1 go RD_BURST, waitrequest=1 there. Leave RD_BURST after issuing beat N-1 (cycle T+N-1); IDLE at T+N.
- Write accept (cycle T): beat 0 written to A with byteenable. If N>1 go WR_BURST, waitrequest=0; each cycle with write=1 writes next word; write=0 is a master stall (no write, counter holds). After beat N-1 return to IDLE.
- Address arithmetic modulo 2^ADDR_W; bursts wrap from max word to 0.
- burstcount=0: treated as 1, err set.
- read and write both high in IDLE: write wins, read dropped, err set.
- read high in WR_BURST: ignored, err set. write high in RD_BURST: ignored (waitrequest=1), no error.
- err cleared only by reset.

## Timing

- Read latency: readdatavalid for beat k at T+1+k; beats contiguous, no bubbles.
- Back-to-back reads: next command accepted at T+N, its first beat at T+N+1 — valid stream gapless.
- Write: zero latency; data visible to a read accepted in the following cycle.
- Reset values: waitrequest=1 while rst_n=0, readdatavalid=0, readdata=0, err=0, state IDLE, counters 0. RAM contents not reset.
- Reset mid-burst: burst abandoned; no further readdatavalid from cycle after rst_n sampled low; pending write beats discarded.

## Structure

- Package avmm_pkg: state enum (IDLE, RD_BURST, WR_BURST), default DATA_W/BURST_W constants.
- Sub-module be_sp_ram: single-port byte-enabled RAM, registered read, one-cycle latency, inferable as BRAM.
- Top: FSM, beat counter (BURST_W), address counter (ADDR_W), readdatavalid pipeline register, err flag.

## Test plan

- Write burst A=0x010, N=4, data 0x…A0..A3, byteenable all-ones; read burst A=0x010, N=4 -> readdatavalid at T+1..T+4 returning A0..A3, waitrequest high T+1..T+3.
- Partial write byteenable=0x000F to word filled with 0xFF..FF with data 0 -> read returns low 4 bytes 0, rest 0xFF.
- Burst wrap: write A=0xFFE, N=4 -> words 0xFFE, 0xFFF, 0x000, 0x001 written; readback matches.
- Two back-to-back reads N=2 and N=3 -> five consecutive readdatavalid cycles, no gap.
- Write burst N=3 with write deasserted 2 cycles after beat 0 -> beats 1,2 land at A+1, A+2; no extra writes.
- Error/reset: read+write together -> write performed, err=1; rst_n low during N=8 read after 3 beats -> readdatavalid 0 from next cycle, err=0, waitrequest=1 until release.
